// File: rtl/ro_meter_pkg.sv
// Shared definitions for the ring-oscillator frequency meter: FSM states and
// default build constants.
package ro_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } ro_state_e;

    localparam int DEF_NUM_CH        = 16;
    localparam int DEF_CNT_W         = 24;
    localparam int DEF_GATE_W        = 24;
    localparam int DEF_SETTLE_CYCLES = 3;

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchroniser plus rise detector for an oscillator output entering
// the system clock domain.
module ro_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic s1_q, s2_q, prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator output mux with a gated edge-counting frequency meter on
// the latched channel; single-shot or continuous windows, abortable.
module ro_freq_meter
    import ro_meter_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int SEL_W         = $clog2(NUM_CH),
    parameter int CNT_W         = DEF_CNT_W,
    parameter int GATE_W        = DEF_GATE_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [NUM_CH-1:0] ro_in,
    input  logic [SEL_W-1:0]  ch_sel,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    output logic              ro_mux_o,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int               STL_W   = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Out-of-range selects read as a constant 0 rather than aliasing.
    function automatic logic pick(input logic [NUM_CH-1:0] v,
                                  input logic [SEL_W-1:0]  s);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (s == SEL_W'(i)) r = v[i];
        end
        return r;
    endfunction

    ro_state_e          state_q;
    logic [SEL_W-1:0]   lat_sel_q;
    logic [GATE_W-1:0]  lat_gate_q;
    logic               lat_cont_q;
    logic [STL_W-1:0]   stl_cnt_q;
    logic [GATE_W-1:0]  gate_cnt_q;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic               sat_q, sat_d;
    logic               meas_in, rise;

    assign ro_mux_o = pick(ro_in, ch_sel);
    assign meas_in  = pick(ro_in, lat_sel_q);

    ro_edge_sync u_sync (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .d_i    (meas_in),
        .rise_o (rise)
    );

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        if (rise) begin
            if (edge_cnt_q == CNT_MAX) sat_d = 1'b1;
            else                       edge_cnt_d = edge_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
            overflow   <= 1'b0;
            lat_cont_q <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                busy    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            lat_sel_q  <= ch_sel;
                            lat_gate_q <= gate_cycles;
                            lat_cont_q <= cont;
                            stl_cnt_q  <= '0;
                            busy       <= 1'b1;
                            state_q    <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        edge_cnt_q <= '0;
                        gate_cnt_q <= '0;
                        sat_q      <= 1'b0;
                        if (stl_cnt_q == STL_W'(SETTLE_CYCLES - 1)) begin
                            state_q <= (lat_gate_q == '0) ? REPORT : MEASURE;
                        end else begin
                            stl_cnt_q <= stl_cnt_q + STL_W'(1);
                        end
                    end
                    MEASURE: begin
                        gate_cnt_q <= gate_cnt_q + GATE_W'(1);
                        edge_cnt_q <= edge_cnt_d;
                        sat_q      <= sat_d;
                        if (gate_cnt_q == lat_gate_q - GATE_W'(1)) state_q <= REPORT;
                    end
                    REPORT: begin
                        count      <= edge_cnt_q;
                        overflow   <= sat_q;
                        done       <= 1'b1;
                        edge_cnt_q <= '0;
                        gate_cnt_q <= '0;
                        sat_q      <= 1'b0;
                        lat_cont_q <= cont;
                        // A single-shot run stays single-shot even if cont rises mid-window.
                        if (lat_cont_q && cont) begin
                            state_q <= MEASURE;
                        end else begin
                            state_q <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: default build plus CNT_W=4 and NUM_CH=12
// builds sharing one stimulus stream.
module tb_ro_freq_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ro;
    logic [1:0]  ph;
    logic [3:0]  ch_sel;
    logic [23:0] gate_cycles;
    logic        start, cont, abort;

    logic        mux_a, busy_a, done_a, ovf_a;
    logic [23:0] cnt_a;
    logic        mux_b, busy_b, done_b, ovf_b;
    logic [3:0]  cnt_b;
    logic        mux_c, busy_c, done_c, ovf_c;
    logic [23:0] cnt_c;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    initial begin
        ph = 2'd0;
        forever begin
            @(negedge clk);
            ph = ph + 2'd1;
        end
    end

    // ro[3]-style channels: period 4; ro[0] and ro[5]: period 2.
    always_comb begin
        ro    = {16{ph[1]}};
        ro[0] = ph[0];
        ro[5] = ph[0];
    end

    ro_freq_meter dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .ro_in(ro), .ch_sel(ch_sel),
        .gate_cycles(gate_cycles), .start(start), .cont(cont), .abort(abort),
        .ro_mux_o(mux_a), .busy(busy_a), .done(done_a), .count(cnt_a), .overflow(ovf_a)
    );

    ro_freq_meter #(.CNT_W(4)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .ro_in(ro), .ch_sel(ch_sel),
        .gate_cycles(gate_cycles), .start(start), .cont(cont), .abort(abort),
        .ro_mux_o(mux_b), .busy(busy_b), .done(done_b), .count(cnt_b), .overflow(ovf_b)
    );

    ro_freq_meter #(.NUM_CH(12)) dut_c (
        .wb_clk_i(clk), .wb_rst_i(rst), .ro_in(ro[11:0]), .ch_sel(ch_sel),
        .gate_cycles(gate_cycles), .start(start), .cont(cont), .abort(abort),
        .ro_mux_o(mux_c), .busy(busy_c), .done(done_c), .count(cnt_c), .overflow(ovf_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Leaves the bench at the negedge of cycle 0 (the start edge is edge 0).
    task automatic do_start(input logic [3:0] sel, input logic [23:0] gate, input logic c);
        ch_sel      = sel;
        gate_cycles = gate;
        cont        = c;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Advances at least one cycle, returns cycles elapsed until done is seen.
    task automatic wait_done(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_a && n < lim);
    endtask

    task automatic idle_cycles(input int k, output int dones);
        dones = 0;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            if (done_a) dones++;
        end
    endtask

    int n, d;

    initial begin
        rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0;
        ch_sel = 4'd0; gate_cycles = 24'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_done", 32'(done_a), 32'd0);
        check_eq("rst_count", 32'(cnt_a), 32'd0);
        check_eq("rst_ovf", 32'(ovf_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Period-4 input, 100-cycle window.
        do_start(4'd3, 24'd100, 1'b0);
        check_eq("p4_busy", 32'(busy_a), 32'd1);
        wait_done(200, n);
        check_eq("p4_latency", 32'(n), 32'd104);
        check_eq("p4_count", 32'(cnt_a), 32'd25);
        check_eq("p4_ovf", 32'(ovf_a), 32'd0);
        @(negedge clk);
        check_eq("p4_done_pulse", 32'(done_a), 32'd0);
        check_eq("p4_count_hold", 32'(cnt_a), 32'd25);

        // Period-2 input, 64-cycle window: saturates the 4-bit build only.
        do_start(4'd0, 24'd64, 1'b0);
        wait_done(200, n);
        check_eq("p2_latency", 32'(n), 32'd68);
        check_eq("p2_cnt4_count", 32'(cnt_b), 32'd15);
        check_eq("p2_cnt4_ovf", 32'(ovf_b), 32'd1);
        check_eq("p2_cnt24_count", 32'(cnt_a), 32'd32);
        check_eq("p2_cnt24_ovf", 32'(ovf_a), 32'd0);
        @(negedge clk);

        // Zero-length window.
        do_start(4'd3, 24'd0, 1'b0);
        wait_done(50, n);
        check_eq("g0_latency", 32'(n), 32'd4);
        check_eq("g0_count", 32'(cnt_a), 32'd0);
        check_eq("g0_ovf", 32'(ovf_a), 32'd0);
        @(negedge clk);

        // Continuous mode, 20-cycle windows.
        do_start(4'd3, 24'd20, 1'b1);
        wait_done(100, n);
        check_eq("cont_first_latency", 32'(n), 32'd24);
        check_eq("cont_first_count", 32'(cnt_a), 32'd5);
        check_eq("cont_mux_before", 32'(mux_a), 32'(ro[3]));
        ch_sel = 4'd5;
        #1;
        check_eq("cont_mux_follow", 32'(mux_a), 32'(ro[5]));
        for (int k = 0; k < 2; k++) begin
            wait_done(100, n);
            check_eq("cont_period", 32'(n), 32'd21);
            check_eq("cont_count", 32'(cnt_a), 32'd5);
            check_eq("cont_busy", 32'(busy_a), 32'd1);
        end
        cont = 1'b0;
        wait_done(100, n);
        check_eq("cont_last_period", 32'(n), 32'd21);
        check_eq("cont_last_count", 32'(cnt_a), 32'd5);
        check_eq("cont_stop_busy", 32'(busy_a), 32'd0);
        idle_cycles(30, d);
        check_eq("cont_stop_nodone", 32'(d), 32'd0);

        // Abort sampled at edge 10.
        do_start(4'd0, 24'd100, 1'b0);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy_a), 32'd0);
        idle_cycles(120, d);
        check_eq("abort_nodone", 32'(d), 32'd0);
        check_eq("abort_count_kept", 32'(cnt_a), 32'd5);

        // Start with abort held: stays idle.
        abort = 1'b1;
        do_start(4'd3, 24'd10, 1'b0);
        abort = 1'b0;
        check_eq("abort_start_busy", 32'(busy_a), 32'd0);
        idle_cycles(20, d);
        check_eq("abort_start_nodone", 32'(d), 32'd0);

        // Reset during MEASURE.
        do_start(4'd3, 24'd100, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("mrst_busy_before", 32'(busy_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mrst_busy", 32'(busy_a), 32'd0);
        check_eq("mrst_count", 32'(cnt_a), 32'd0);
        check_eq("mrst_ovf", 32'(ovf_a), 32'd0);
        idle_cycles(110, d);
        check_eq("mrst_nodone", 32'(d), 32'd0);

        // Out-of-range channel on the 12-channel build.
        do_start(4'd12, 24'd40, 1'b0);
        check_eq("oor_mux12", 32'(mux_c), 32'd0);
        check_eq("oor_mux16", 32'(mux_a), 32'(ro[12]));
        wait_done(100, n);
        check_eq("oor_latency", 32'(n), 32'd44);
        check_eq("oor_done12", 32'(done_c), 32'd1);
        check_eq("oor_count12", 32'(cnt_c), 32'd0);
        check_eq("oor_ovf12", 32'(ovf_c), 32'd0);
        check_eq("oor_count16", 32'(cnt_a), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
